mem_copy_engine: RTL

- Requester-side controller for the team's 256x8 synchronous sequential memory: addr/w/data inputs, registered read data on out.
- Copies LEN bytes from SRC to DST inside one memory instance, byte by byte in ascending order.
- Issues single-cycle write strobes and read requests, and accounts for the memory's one-edge read latency.
- Sits between a host/test sequencer and a sequential_memory instance as that memory's only driver.

---
 rtl/mem_copy_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Purpose:
//   Requester-side controller for a synchronous sequential memory with a
//   registered read port. It copies len bytes from src to dst within that one
//   memory, one byte at a time and in ascending order. Each byte takes three
//   cycles: RD presents the source address, WAIT captures the registered read
//   data, and WR writes the byte to the destination. Address arithmetic wraps
//   modulo 2**AW.
//
// Optional feature:
//   MEM_COPY_CHECKSUM_EN - when defined, checksum accumulates every copied byte
//   (mod 2**DW). When undefined, checksum is tied to zero and no adder exists.
//
// Ports:
//   clk       in   rising-edge clock, shared with the memory
//   rst       in   synchronous active-high reset, wins over every input
//   start     in   request pulse, sampled only in IDLE
//   src       in   [AW] source base address, latched on acceptance
//   dst       in   [AW] destination base address, latched on acceptance
//   len       in   [AW] byte count, latched on acceptance (0 = no transfer)
//   busy      out  high in RD, WAIT and WR
//   done      out  one-cycle completion pulse (DONE state)
//   count     out  [AW] bytes written so far in the current transfer
//   checksum  out  [DW] running sum of copied bytes
//   mem_addr  out  [AW] memory address
//   mem_w     out  memory write enable, high only in WR
//   mem_data  out  [DW] memory write data
//   mem_out   in   [DW] memory read data, valid the cycle after a read edge
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic [DW-1:0] checksum,
  output logic [AW-1:0] mem_addr,
  output logic          mem_w,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] count_q, count_d;
  logic [DW-1:0] data_q, data_d;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;
`endif

  // State and datapath registers; rst returns everything to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      data_q  <= data_d;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    data_d  = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src;
            dst_d   = dst;
            len_d   = len;
            count_d = '0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_d = '0;
`endif
            state_d = S_RD;
          end else begin
            // Zero-length request: complete without touching memory.
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        // The memory registers the read during this cycle's closing edge.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        data_d  = mem_out;
        state_d = S_WR;
      end
      S_WR: begin
        count_d = count_q + AW'(1);
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d = checksum_q + data_q;
`endif
        if ((count_q + AW'(1)) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side and status outputs, decoded purely from registered state.
  always_comb begin
    mem_addr = '0;
    mem_w    = 1'b0;
    mem_data = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_RD, S_WAIT: begin
        mem_addr = src_q + count_q;
        busy     = 1'b1;
      end
      S_WR: begin
        mem_addr = dst_q + count_q;
        mem_w    = 1'b1;
        mem_data = data_q;
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign count = count_q;

`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
